// File: rtl/data_memory_sized_if.sv
// Request/response bundle for data_memory_sized.
// master = requester (MEM stage), slave = the memory.
interface data_memory_sized_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           writeData;
    logic                  memWrite;
    logic                  memRead;
    logic [1:0]            size;
    logic                  unsignedLoad;
    logic [31:0]           readData;
    logic                  resp_valid;
    logic                  misaligned;
    logic                  outOfRange;

    modport master (
        output req_valid, address, writeData, memWrite, memRead,
               size, unsignedLoad,
        input  req_ready, readData, resp_valid, misaligned, outOfRange
    );

    modport slave (
        input  req_valid, address, writeData, memWrite, memRead,
               size, unsignedLoad,
        output req_ready, readData, resp_valid, misaligned, outOfRange
    );
endinterface

// File: rtl/data_memory_sized.sv
// Byte-addressable little-endian data memory, byte/half/word access,
// valid/ready request, WAIT_STATES-cycle wait FSM, alignment/range flags.
// Ports: CLK, RST (sync, active-high), bus (data_memory_sized_if.slave).
module data_memory_sized #(
    parameter int DEPTH_BYTES  = 1024,
    parameter int ADDR_WIDTH   = 32,
    parameter int WAIT_STATES  = 0,
    parameter int INIT_PATTERN = 1
) (
    input logic CLK,
    input logic RST,
    data_memory_sized_if.slave bus
);
    localparam int IW = $clog2(DEPTH_BYTES);
    localparam int MB = DEPTH_BYTES * 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic logic [MB-1:0] init_mem();
        logic [MB-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH_BYTES; i++) begin
            v[8*i +: 8] = (INIT_PATTERN != 0) ? 8'(i) : 8'h00;
        end
        return v;
    endfunction

    // Flat byte store; contents survive reset, set up only at time zero.
    logic [MB-1:0] mem = init_mem();

    state_t        state;
    logic [3:0]    cnt;
    logic          rdy;
    logic          rv;
    logic          mis;
    logic          oor;
    logic [31:0]   rdata;

    logic [IW-1:0] lat_idx;
    logic [31:0]   lat_wd;
    logic          lat_w;
    logic          lat_r;
    logic [1:0]    lat_size;
    logic          lat_uns;
    logic          lat_mis;
    logic          lat_oor;

    logic [2:0]            nb;
    logic [ADDR_WIDTH:0]   end_addr;
    logic                  mis_c;
    logic                  oor_c;
    logic                  op_c;
    logic [31:0]           rd_word;
    logic [31:0]           ext;
    logic [3:0]            be;
    logic                  err;

    // Request checks: end address is one bit wider so no wrap is possible.
    always_comb begin
        unique case (bus.size)
            2'b00:   nb = 3'd1;
            2'b01:   nb = 3'd2;
            default: nb = 3'd4;
        endcase
        end_addr = {1'b0, bus.address} + {{(ADDR_WIDTH - 2){1'b0}}, nb};
        op_c  = bus.memRead | bus.memWrite;
        mis_c = op_c & ((bus.size == 2'b11) |
                        ((bus.size == 2'b01) & bus.address[0]) |
                        ((bus.size == 2'b10) & (bus.address[1:0] != 2'b00)));
        oor_c = op_c & (end_addr > DEPTH_EXT);
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 4; k++) begin
            rd_word[8*k +: 8] = mem[{lat_idx + IW'(k), 3'b000} +: 8];
        end
        unique case (lat_size)
            2'b00:   ext = {{24{~lat_uns & rd_word[7]}}, rd_word[7:0]};
            2'b01:   ext = {{16{~lat_uns & rd_word[15]}}, rd_word[15:0]};
            default: ext = rd_word;
        endcase
        unique case (lat_size)
            2'b00:   be = 4'b0001;
            2'b01:   be = 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        err = lat_mis | lat_oor;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            rdy   <= 1'b1;
            rv    <= 1'b0;
            mis   <= 1'b0;
            oor   <= 1'b0;
            rdata <= '0;
        end else begin
            rv <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_idx  <= bus.address[IW-1:0];
                        lat_wd   <= bus.writeData;
                        lat_w    <= bus.memWrite;
                        lat_r    <= bus.memRead;
                        lat_size <= bus.size;
                        lat_uns  <= bus.unsignedLoad;
                        lat_mis  <= mis_c;
                        lat_oor  <= oor_c;
                        rdy      <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            cnt   <= 4'(WAIT_STATES);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    rv    <= 1'b1;
                    mis   <= lat_mis;
                    oor   <= lat_oor;
                    // Read uses pre-store contents; store commits same edge.
                    rdata <= (lat_r && !err) ? ext : 32'h0;
                    if (lat_w && !err) begin
                        for (int k = 0; k < 4; k++) begin
                            if (be[k]) begin
                                mem[{lat_idx + IW'(k), 3'b000} +: 8] <= lat_wd[8*k +: 8];
                            end
                        end
                    end
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = rdy;
    assign bus.resp_valid = rv;
    assign bus.misaligned = mis;
    assign bus.outOfRange = oor;
    assign bus.readData   = rdata;
endmodule
